// File: rtl/gpr_ctrl_pkg.sv
// Shared definitions for the general-purpose register transfer sequencer.
package gpr_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned OP_W      = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MOV  = 2'b00,
        OP_LDI  = 2'b01,
        OP_SWAP = 2'b10,
        OP_CLR  = 2'b11
    } opT;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        FIN  = 3'd4
    } stateT;

endpackage

// File: rtl/gpr_xfer_ctrl.sv
// Sequences MOV/LDI/SWAP/CLR commands into register-file select/enable strobes,
// one bus transfer per cycle, with registered outputs derived from the next state.
module gpr_xfer_ctrl
    import gpr_ctrl_pkg::*;
#(
    parameter int unsigned SCRATCH = 7,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic [OP_W-1:0]      cmdOp,
    input  logic [REG_IDX_W-1:0] cmdRd,
    input  logic [REG_IDX_W-1:0] cmdRs,
    input  logic [WIDTH-1:0]     cmdImm,
    output logic [REG_IDX_W-1:0] rInSel,
    output logic                 rInEn,
    output logic [REG_IDX_W-1:0] rOutSel,
    output logic                 rOutEn,
    output logic [WIDTH-1:0]     immOut,
    output logic                 immOutEn,
    output logic                 done,
    output logic                 err
);

    localparam logic [REG_IDX_W-1:0] SCR_IDX = REG_IDX_W'(SCRATCH);

    stateT                state, stateNext;
    opT                   opQ, opN;
    logic [REG_IDX_W-1:0] rdQ, rdN, rsQ, rsN;
    logic [WIDTH-1:0]     immQ, immN;
    logic                 rejQ, rejN;
    logic                 accept;

    logic [REG_IDX_W-1:0] inSelN, outSelN;
    logic                 inEnN, outEnN, immEnN, doneN, errN, readyN;
    logic [WIDTH-1:0]     immOutN;

    // Next state, next latched fields and next registered outputs
    always_comb begin
        stateNext = state;
        accept    = (state == IDLE) && cmdValid;
        opN       = opQ;
        rdN       = rdQ;
        rsN       = rsQ;
        immN      = immQ;
        rejN      = rejQ;
        inSelN    = '0;
        outSelN   = '0;
        inEnN     = 1'b0;
        outEnN    = 1'b0;
        immEnN    = 1'b0;
        immOutN   = '0;
        doneN     = 1'b0;
        errN      = 1'b0;
        readyN    = 1'b0;

        if (accept) begin
            opN  = opT'(cmdOp);
            rdN  = cmdRd;
            rsN  = cmdRs;
            immN = cmdImm;
            rejN = (opN == OP_SWAP) && (rdN != rsN) && ((rdN == SCR_IDX) || (rsN == SCR_IDX));
        end

        case (state)
            IDLE: if (accept) begin
                if ((opN == OP_SWAP) && ((rdN == rsN) || rejN)) stateNext = FIN;
                else                                            stateNext = T1;
            end
            T1:      stateNext = (opQ == OP_SWAP) ? T2 : FIN;
            T2:      stateNext = T3;
            T3:      stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // SWAP routes rd -> scratch -> ... so the first transfer depends on the opcode
        case (stateNext)
            IDLE: readyN = 1'b1;
            T1: begin
                inEnN = 1'b1;
                case (opN)
                    OP_SWAP: begin inSelN = SCR_IDX; outSelN = rdN; outEnN = 1'b1; end
                    OP_MOV:  begin inSelN = rdN;     outSelN = rsN; outEnN = 1'b1; end
                    OP_LDI:  begin inSelN = rdN;     immEnN = 1'b1; immOutN = immN; end
                    default: begin inSelN = rdN;     immEnN = 1'b1; immOutN = '0;   end
                endcase
            end
            T2: begin inEnN = 1'b1; inSelN = rdN; outSelN = rsN;     outEnN = 1'b1; end
            T3: begin inEnN = 1'b1; inSelN = rsN; outSelN = SCR_IDX; outEnN = 1'b1; end
            FIN: begin doneN = 1'b1; errN = rejN; end
            default: readyN = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opQ   <= OP_MOV;
            rdQ   <= '0;
            rsQ   <= '0;
            immQ  <= '0;
            rejQ  <= 1'b0;
        end else begin
            state <= stateNext;
            opQ   <= opN;
            rdQ   <= rdN;
            rsQ   <= rsN;
            immQ  <= immN;
            rejQ  <= rejN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmdReady <= 1'b1;
            rInSel   <= '0;
            rInEn    <= 1'b0;
            rOutSel  <= '0;
            rOutEn   <= 1'b0;
            immOut   <= '0;
            immOutEn <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cmdReady <= readyN;
            rInSel   <= inSelN;
            rInEn    <= inEnN;
            rOutSel  <= outSelN;
            rOutEn   <= outEnN;
            immOut   <= immOutN;
            immOutEn <= immEnN;
            done     <= doneN;
            err      <= errN;
        end
    end

endmodule

// File: tb/tb_gpr_xfer_ctrl.sv
// Directed bench for gpr_xfer_ctrl driving a behavioural 8x8 register file on a shared bus.
module tb_gpr_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [1:0] cmdOp = 2'b00;
    logic [2:0] cmdRd = 3'd0;
    logic [2:0] cmdRs = 3'd0;
    logic [7:0] cmdImm = 8'h00;
    logic [2:0] rInSel, rOutSel;
    logic       rInEn, rOutEn, immOutEn, done, err;
    logic [7:0] immOut;

    int compared = 0;
    int failed   = 0;

    gpr_xfer_ctrl #(.SCRATCH(7), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdRd(cmdRd), .cmdRs(cmdRs), .cmdImm(cmdImm),
        .rInSel(rInSel), .rInEn(rInEn), .rOutSel(rOutSel), .rOutEn(rOutEn),
        .immOut(immOut), .immOutEn(immOutEn), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register file and bus model
    logic [7:0] rf [8];
    logic [7:0] bus;
    assign bus = rOutEn ? rf[rOutSel] : (immOutEn ? immOut : 8'h00);
    always @(posedge clk) if (rInEn) rf[rInSel] <= bus;

    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            if ((rOutEn && immOutEn) || (rInEn && !(rOutEn || immOutEn))) begin
                failed++;
                $display("FAIL busInvariant at %0t: rInEn=%0b rOutEn=%0b immOutEn=%0b required no contention and a driver per write",
                         $time, rInEn, rOutEn, immOutEn);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    logic [2:0] inLog [4];
    logic [2:0] outLog [4];
    logic       outEnLog [4];
    logic       immEnLog [4];
    logic [7:0] immLog [4];
    time        acceptT;

    // Issue one command; returns cycles from acceptance to done, err seen, write count
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [7:0] imm, input bit junk,
                         output int lat, output logic errSeen, output int writes);
        int waitCnt = 0;
        bit seen = 0;
        lat = 0; errSeen = 1'b0; writes = 0;
        while (!cmdReady && waitCnt < 20) begin @(negedge clk); waitCnt++; end
        if (!cmdReady) begin
            chk("readyTimeout", 0, 1);
            return;
        end
        cmdValid = 1'b1; cmdOp = op; cmdRd = rd; cmdRs = rs; cmdImm = imm;
        @(posedge clk);
        acceptT = $time;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (junk) begin
                cmdOp = 2'($urandom_range(0, 3)); cmdRd = 3'($urandom_range(0, 7));
                cmdRs = 3'($urandom_range(0, 7)); cmdImm = 8'($urandom_range(0, 255));
            end else cmdValid = 1'b0;
            if (rInEn) begin
                if (writes < 4) begin
                    inLog[writes] = rInSel; outLog[writes] = rOutSel;
                    outEnLog[writes] = rOutEn; immEnLog[writes] = immOutEn; immLog[writes] = immOut;
                end
                writes++;
            end
            if (done) begin
                seen = 1; lat = k; errSeen = err; cmdValid = 1'b0;
            end
        end
        if (!seen) begin
            chk("doneTimeout", 0, 1);
            return;
        end
        @(negedge clk);
        chk("readyAfterDone", int'(cmdReady), 1);
        chk("donePulseWidth", int'(done), 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        int         lat;
        logic       err;
        int         writes;
        logic [2:0] chkReg;
        logic [7:0] chkVal;
    } vecT;

    vecT vecs [12];

    initial begin
        int lat, writes;
        logic errSeen;
        time t0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;

        vecs[0]  = '{2'b01, 3'd3, 3'd0, 8'hA5, 2, 1'b0, 1, 3'd3, 8'hA5};
        vecs[1]  = '{2'b00, 3'd5, 3'd3, 8'h00, 2, 1'b0, 1, 3'd5, 8'hA5};
        vecs[2]  = '{2'b01, 3'd1, 3'd0, 8'h11, 2, 1'b0, 1, 3'd1, 8'h11};
        vecs[3]  = '{2'b01, 3'd2, 3'd0, 8'h22, 2, 1'b0, 1, 3'd2, 8'h22};
        vecs[4]  = '{2'b10, 3'd1, 3'd2, 8'h00, 4, 1'b0, 3, 3'd1, 8'h22};
        vecs[5]  = '{2'b01, 3'd4, 3'd0, 8'h44, 2, 1'b0, 1, 3'd4, 8'h44};
        vecs[6]  = '{2'b10, 3'd4, 3'd7, 8'h00, 1, 1'b1, 0, 3'd4, 8'h44};
        vecs[7]  = '{2'b10, 3'd6, 3'd6, 8'h00, 1, 1'b0, 0, 3'd6, 8'h00};
        vecs[8]  = '{2'b01, 3'd0, 3'd0, 8'hFF, 2, 1'b0, 1, 3'd0, 8'hFF};
        vecs[9]  = '{2'b11, 3'd0, 3'd0, 8'h5A, 2, 1'b0, 1, 3'd0, 8'h00};
        vecs[10] = '{2'b00, 3'd3, 3'd3, 8'h00, 2, 1'b0, 1, 3'd3, 8'hA5};
        vecs[11] = '{2'b10, 3'd7, 3'd2, 8'h00, 1, 1'b1, 0, 3'd7, 8'h11};

        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rstReady", int'(cmdReady), 1);
        chk("rstEnables", int'({rInEn, rOutEn, immOutEn, done, err}), 0);
        chk("rstSelects", int'({rInSel, rOutSel, immOut}), 0);
        rst = 1'b0;

        // Reset asserted in T2 of a SWAP
        @(negedge clk);
        cmdValid = 1'b1; cmdOp = 2'b10; cmdRd = 3'd1; cmdRs = 3'd2;
        @(negedge clk);
        cmdValid = 1'b0;
        chk("swapT1Write", int'(rInEn), 1);
        @(negedge clk);
        chk("swapT2InSel", int'(rInSel), 1);
        rst = 1'b1;
        #1;
        chk("midRstEnables", int'({rInEn, rOutEn, immOutEn, done}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postRstReady", int'(cmdReady), 1);
        @(negedge clk);
        chk("postRstNoDone", int'(done), 0);
        chk("postRstIdle", int'(cmdReady), 1);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, 1'b0, lat, errSeen, writes);
            chk($sformatf("vec%0d.latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d.err", i), int'(errSeen), int'(vecs[i].err));
            chk($sformatf("vec%0d.writes", i), writes, vecs[i].writes);
            chk($sformatf("vec%0d.reg", i), int'(rf[vecs[i].chkReg]), int'(vecs[i].chkVal));
        end
        chk("rejSwapKeepsR4", int'(rf[4]), 8'h44);

        // LDI first-transfer strobes
        issue(2'b01, 3'd3, 3'd6, 8'h5C, 1'b0, lat, errSeen, writes);
        chk("ldiImmEn", int'(immEnLog[0]), 1);
        chk("ldiImm", int'(immLog[0]), 8'h5C);
        chk("ldiInSel", int'(inLog[0]), 3);
        chk("ldiNoRegDrive", int'(outEnLog[0]), 0);

        // Back-to-back commands are accepted every 3 cycles
        issue(2'b00, 3'd5, 3'd3, 8'h00, 1'b0, lat, errSeen, writes);
        t0 = acceptT;
        issue(2'b00, 3'd6, 3'd5, 8'h00, 1'b0, lat, errSeen, writes);
        chk("backToBackCycles", int'((acceptT - t0) / 10), 3);
        chk("chainR6", int'(rf[6]), 8'h5C);

        // SWAP select sequence, r1=0x22 r2=0x11 beforehand
        issue(2'b10, 3'd1, 3'd2, 8'h00, 1'b0, lat, errSeen, writes);
        chk("swapSel0", int'({inLog[0], outLog[0], outEnLog[0]}), int'({3'd7, 3'd1, 1'b1}));
        chk("swapSel1", int'({inLog[1], outLog[1], outEnLog[1]}), int'({3'd1, 3'd2, 1'b1}));
        chk("swapSel2", int'({inLog[2], outLog[2], outEnLog[2]}), int'({3'd2, 3'd7, 1'b1}));
        chk("swapR1", int'(rf[1]), 8'h11);
        chk("swapR2", int'(rf[2]), 8'h22);
        chk("swapR7", int'(rf[7]), 8'h22);
        chk("swapLatency", lat, 4);

        // cmdValid held with changing fields while busy
        issue(2'b00, 3'd4, 3'd3, 8'h00, 1'b1, lat, errSeen, writes);
        chk("busyWrites", writes, 1);
        chk("busyR4", int'(rf[4]), 8'h5C);
        chk("busyR0", int'(rf[0]), 8'h00);
        chk("busyR1", int'(rf[1]), 8'h11);
        chk("busyR2", int'(rf[2]), 8'h22);
        @(negedge clk);
        chk("busyIdleAfter", int'(cmdReady), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
